ddr_cmd_arbiter: RTL

Parametrised successor to the DDR dispatch stage: pops queued read addresses and write address/data pairs from the DDR FIFOs and drives the memory-controller app interface. Generalises beats per write word, address/data widths and arbitration fairness via a bounded run length. Sits between `ddr_fifo` and the DDR controller app port.

---
 rtl/ddr_pkg.sv | 13 +
 rtl/ddr_wdf_serializer.sv | 67 ++++++
 rtl/ddr_cmd_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared encodings for the DDR command dispatch path: app commands, mode bit and arbiter state.
package ddr_pkg;
  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam logic       MODE_READ  = 1'b1;
  localparam logic       MODE_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_ARB = 2'd0,
    ST_RD  = 2'd1,
    ST_WR  = 2'd2
  } state_e;
endpackage

// File: rtl/ddr_wdf_serializer.sv
// Splits one FIFO write word into BEATS app beats, beat 0 first; first beat valid the cycle after load.
// Each beat holds until wdf_rdy; done is high when nothing is pending after the current cycle.
module ddr_wdf_serializer #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic [BEATS*DATA_W-1:0]   word_in,
  input  logic                      wdf_rdy,
  output logic [DATA_W-1:0]         wdf_data,
  output logic                      wdf_wren,
  output logic                      wdf_end,
  output logic                      done
);
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W = BEATS * DATA_W;

  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              wren_q, wren_d;
  logic              end_q, end_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
      beat_q <= '0;
      wren_q <= 1'b0;
      end_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      beat_q <= beat_d;
      wren_q <= wren_d;
      end_q  <= end_d;
    end
  end

  // The current beat always sits in the low slice, so the output is a plain flop.
  always_comb begin
    word_d = word_q;
    beat_d = beat_q;
    wren_d = wren_q;
    end_d  = end_q;
    if (load) begin
      word_d = word_in;
      beat_d = '0;
      wren_d = 1'b1;
      end_d  = (BEATS == 1);
    end else if (wren_q && wdf_rdy) begin
      if (end_q) begin
        wren_d = 1'b0;
        end_d  = 1'b0;
        beat_d = '0;
      end else begin
        word_d = word_q >> DATA_W;
        beat_d = beat_q + BW'(1);
        end_d  = ((beat_q + BW'(1)) == BW'(BEATS - 1));
      end
    end
  end

  assign wdf_data = word_q[DATA_W-1:0];
  assign wdf_wren = wren_q;
  assign wdf_end  = end_q;
  assign done     = !wren_q || (wdf_rdy && end_q);
endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Pops DDR read/write FIFOs and drives the app port; command one cycle after pop, reads sustain one per cycle.
// Holds each command on app_rdy and each beat on app_wdf_rdy; no FIFO pop while a transaction is outstanding.
module ddr_cmd_arbiter
  import ddr_pkg::*;
#(
  parameter int ADDR_W     = 27,
  parameter int APP_DATA_W = 64,
  parameter int BEATS      = 2,
  parameter int MAX_RUN    = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          has_wr_adx,
  input  logic                          has_wr_data,
  input  logic [ADDR_W-1:0]             wr_adx_in,
  input  logic [BEATS*APP_DATA_W-1:0]   wr_data_in,
  output logic                          get_wr_adx,
  output logic                          get_wr_data,
  input  logic                          has_rd_req,
  input  logic [ADDR_W-1:0]             rd_adx_in,
  output logic                          get_rd_req,
  output logic [ADDR_W-1:0]             app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [APP_DATA_W-1:0]         app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  input  logic                          app_wdf_rdy,
  output logic                          mode,
  output logic                          busy
);
  localparam int RUN_W = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                app_en_q, app_en_d;
  logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic [2:0]          app_cmd_q, app_cmd_d;

  logic wr_elig, rd_elig, cur_elig, oth_elig, run_ok;
  logic pick_rd, pick_wr, cmd_acc, issue_rd, issue_wr, wdf_done;

  always_comb begin
    wr_elig  = has_wr_adx && has_wr_data;
    rd_elig  = has_rd_req;
    cur_elig = (mode_q == MODE_READ) ? rd_elig : wr_elig;
    oth_elig = (mode_q == MODE_READ) ? wr_elig : rd_elig;
    run_ok   = (MAX_RUN == 0) || (run_cnt_q < RUN_W'(MAX_RUN));
    pick_rd  = 1'b0;
    pick_wr  = 1'b0;
    // An exhausted run only yields when the other type actually has work.
    if (cur_elig && (run_ok || !oth_elig)) begin
      pick_rd = (mode_q == MODE_READ);
      pick_wr = (mode_q == MODE_WRITE);
    end else if (oth_elig) begin
      pick_rd = (mode_q == MODE_WRITE);
      pick_wr = (mode_q == MODE_READ);
    end
  end

  assign cmd_acc = app_en_q && app_rdy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_ARB;
      mode_q     <= MODE_WRITE;
      run_cnt_q  <= '0;
      app_en_q   <= 1'b0;
      app_addr_q <= '0;
      app_cmd_q  <= CMD_WRITE;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      run_cnt_q  <= run_cnt_d;
      app_en_q   <= app_en_d;
      app_addr_q <= app_addr_d;
      app_cmd_q  <= app_cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (pick_rd) state_d = ST_RD;
               else if (pick_wr) state_d = ST_WR;
      ST_RD:   if (cmd_acc && !pick_rd) state_d = ST_ARB;
      ST_WR:   if ((!app_en_q || app_rdy) && wdf_done) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Pops are gated by resetn so nothing drains the FIFOs while held in reset.
  always_comb begin
    issue_rd   = resetn && pick_rd &&
                 ((state_q == ST_ARB) || ((state_q == ST_RD) && cmd_acc));
    issue_wr   = resetn && pick_wr && (state_q == ST_ARB);
    mode_d     = mode_q;
    run_cnt_d  = run_cnt_q;
    app_en_d   = app_en_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    if (issue_rd || issue_wr) begin
      mode_d = issue_rd ? MODE_READ : MODE_WRITE;
      if (mode_d == mode_q) run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + RUN_W'(1);
      else                  run_cnt_d = RUN_W'(1);
    end
    if (issue_rd) begin
      app_en_d   = 1'b1;
      app_addr_d = rd_adx_in;
      app_cmd_d  = CMD_READ;
    end else if (issue_wr) begin
      app_en_d   = 1'b1;
      app_addr_d = wr_adx_in;
      app_cmd_d  = CMD_WRITE;
    end else if (cmd_acc) begin
      app_en_d   = 1'b0;
    end
  end

  assign get_rd_req  = issue_rd;
  assign get_wr_adx  = issue_wr;
  assign get_wr_data = issue_wr;
  assign app_en      = app_en_q;
  assign app_addr    = app_addr_q;
  assign app_cmd     = app_cmd_q;
  assign mode        = mode_q;
  assign busy        = (state_q != ST_ARB);

  ddr_wdf_serializer #(
    .DATA_W (APP_DATA_W),
    .BEATS  (BEATS)
  ) u_wdf (
    .clk      (clk),
    .resetn   (resetn),
    .load     (issue_wr),
    .word_in  (wr_data_in),
    .wdf_rdy  (app_wdf_rdy),
    .wdf_data (app_wdf_data),
    .wdf_wren (app_wdf_wren),
    .wdf_end  (app_wdf_end),
    .done     (wdf_done)
  );
endmodule
